spi_exe_master: RTL and testbench



---
 rtl/spi_exe_pkg.sv | 23 ++
 rtl/spi_clk_gen.sv | 41 ++++
 rtl/spi_exe_master.sv | 170 +++++++++++++++++
 tb/tb_spi_exe_master.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_exe_pkg.sv
// Shared constants, FSM state type and flag bit positions for the SPI
// execution-unit master.
package spi_exe_pkg;

  localparam int unsigned M    = 8;
  localparam int unsigned N    = 4;
  localparam int unsigned BITS = 2 * M + N;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    LOAD,
    DONE
  } state_t;

  localparam int unsigned SF = 0;
  localparam int unsigned OF = 1;
  localparam int unsigned NF = 2;
  localparam int unsigned BF = 3;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer and SCLK generator. The timer free-runs while enabled; the
// clock only toggles on timer wrap when pulsing is requested.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pulse,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);
  assign rise = tick && pulse && !sclk;
  assign fall = tick && pulse && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (rise)
        sclk <= 1'b1;
      else if (fall)
        sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_exe_master.sv
// SPI mode-0 master for the execution-unit slave: one 20-bit command frame plus
// trailing load clocks per request. SPI_EXE_MASTER_READBACK_EN adds a zero frame.
module spi_exe_master
  import spi_exe_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned LOAD_CLKS = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [M-1:0] i_argA,
  input  logic [M-1:0] i_argB,
  input  logic [N-1:0] i_oper,
  output logic         o_busy,
  output logic         o_done,
  output logic [M-1:0] o_result,
  output logic [N-1:0] o_flags,
  output logic         o_sclk,
  output logic         o_cs,
  output logic         o_mosi,
  input  logic         i_miso
);

  localparam int unsigned BCW = $clog2(BITS + 1);
  localparam int unsigned LCW = $clog2(LOAD_CLKS + 1);

  state_t state, next;

  logic            tick, rise, fall;
  logic            en, pulse, last;
  logic [BITS-1:0] tx, rx;
  logic [BCW-1:0]  bit_cnt;
  logic [LCW-1:0]  load_cnt;

`ifdef SPI_EXE_MASTER_READBACK_EN
  // Set once the command frame is out; only the readback frame completes.
  logic second;
  assign last = second;
`else
  assign last = 1'b1;
`endif

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk   (i_clk),
    .rst   (i_rst),
    .en    (en),
    .pulse (pulse),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall),
    .sclk  (o_sclk)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= next;
  end

  always_comb begin
    next   = state;
    en     = 1'b0;
    pulse  = 1'b0;
    o_cs   = 1'b1;
    o_mosi = 1'b0;
    o_busy = 1'b1;
    o_done = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start)
          next = SETUP;
      end
      SETUP: begin
        en     = 1'b1;
        o_cs   = 1'b0;
        o_mosi = tx[BITS-1];
        if (tick)
          next = SHIFT;
      end
      SHIFT: begin
        en     = 1'b1;
        pulse  = 1'b1;
        o_cs   = 1'b0;
        o_mosi = tx[BITS-1];
        if (fall && bit_cnt == BCW'(1))
          next = HOLD;
      end
      HOLD: begin
        en = 1'b1;
        if (tick)
          next = LOAD;
      end
      LOAD: begin
        en    = 1'b1;
        pulse = 1'b1;
        if (fall && load_cnt == LCW'(1))
          next = DONE;
      end
      DONE: begin
        o_busy = !last;
        o_done = last;
        next   = last ? IDLE : SETUP;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx       <= '0;
      rx       <= '0;
      bit_cnt  <= '0;
      load_cnt <= '0;
      o_result <= '0;
      o_flags  <= '0;
`ifdef SPI_EXE_MASTER_READBACK_EN
      second   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            tx      <= {i_argA, i_argB, i_oper};
            bit_cnt <= BCW'(BITS);
`ifdef SPI_EXE_MASTER_READBACK_EN
            second  <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (rise)
            rx <= {rx[BITS-2:0], i_miso};
          if (fall) begin
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt != BCW'(1))
              tx <= {tx[BITS-2:0], 1'b0};
          end
        end
        HOLD: begin
          if (tick)
            load_cnt <= LCW'(LOAD_CLKS);
        end
        LOAD: begin
          if (fall) begin
            load_cnt <= load_cnt - 1'b1;
            // Response is taken from the first M+N bits; the rest are padding.
            if (load_cnt == LCW'(1) && last) begin
              o_result <= rx[BITS-1 -: M];
              o_flags  <= rx[BITS-1-M -: N];
            end
          end
        end
        DONE: begin
`ifdef SPI_EXE_MASTER_READBACK_EN
          if (!second) begin
            tx      <= '0;
            bit_cnt <= BCW'(BITS);
            second  <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exe_master.sv
// Directed self-checking bench for spi_exe_master with a behavioural mode-0
// slave that answers with the previously loaded command's {A+B, oper}.
module tb_spi_exe_master;

  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned LOAD_CLKS = 2;
`ifdef SPI_EXE_MASTER_READBACK_EN
  localparam int FRAMES = 2;
`else
  localparam int FRAMES = 1;
`endif
  localparam int LAT1 = 1 + CLK_DIV * (1 + 2 * 20 + 1 + 2 * LOAD_CLKS) + 1;
  localparam int LAT  = (FRAMES == 2) ? (LAT1 - 1) * 2 + 1 : LAT1;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] i_argA, i_argB;
  logic [3:0] i_oper;
  logic       o_busy, o_done, o_sclk, o_cs, o_mosi, i_miso;
  logic [7:0] o_result;
  logic [3:0] o_flags;

  spi_exe_master #(.CLK_DIV(CLK_DIV), .LOAD_CLKS(LOAD_CLKS)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_argA   (i_argA),
    .i_argB   (i_argB),
    .i_oper   (i_oper),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_flags  (o_flags),
    .o_sclk   (o_sclk),
    .o_cs     (o_cs),
    .o_mosi   (o_mosi),
    .i_miso   (i_miso)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int fails  = 0;

  logic [39:0] mosi_cap;
  logic [19:0] slave_sr, miso_sr, resp;
  int          low_pulses, high_pulses, frames, load_seen, done_cnt;
  logic        auto_resp;

  assign i_miso = miso_sr[19];

  always @(posedge o_sclk) begin
    if (o_cs === 1'b0) begin
      mosi_cap   = {mosi_cap[38:0], o_mosi};
      slave_sr   = {slave_sr[18:0], o_mosi};
      low_pulses = low_pulses + 1;
    end else begin
      high_pulses = high_pulses + 1;
      load_seen   = load_seen + 1;
      if (auto_resp && load_seen == LOAD_CLKS)
        resp = {slave_sr[19:12] + slave_sr[11:4], slave_sr[3:0], 8'h00};
    end
  end

  always @(negedge o_cs) begin
    frames    = frames + 1;
    load_seen = 0;
    miso_sr   = resp;
  end

  always @(negedge o_sclk)
    if (o_cs === 1'b0)
      miso_sr = {miso_sr[18:0], 1'b0};

  always @(negedge i_clk)
    if (o_done === 1'b1)
      done_cnt = done_cnt + 1;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mosi_cap    = '0;
    low_pulses  = 0;
    high_pulses = 0;
    frames      = 0;
    done_cnt    = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (o_done !== 1'b1 && n < 400) begin
      @(posedge i_clk); #1;
      n++;
    end
  endtask

  // Latency counts the i_start cycle through the o_done cycle inclusive.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output int lat);
    int n;
    @(posedge i_clk); #1;
    i_argA = a; i_argB = b; i_oper = op; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done(n);
    lat = n + 2;
  endtask

  initial begin
    int lat, n;
    i_rst = 1'b1; i_start = 1'b0;
    i_argA = '0; i_argB = '0; i_oper = '0;
    miso_sr = '0; slave_sr = '0; resp = 20'h5A7C3; auto_resp = 1'b0;
    load_seen = 0;
    clear_mon();

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_sclk",   o_sclk,   1'b0);
    check("rst_cs",     o_cs,     1'b1);
    check("rst_mosi",   o_mosi,   1'b0);
    check("rst_busy",   o_busy,   1'b0);
    check("rst_done",   o_done,   1'b0);
    check("rst_result", o_result, 8'h00);
    check("rst_flags",  o_flags,  4'h0);
    i_rst = 1'b0;

    // Frame format, fixed MISO pattern, latency
    clear_mon();
    run_txn(8'hA5, 8'h3C, 4'h1, lat);
    check("lat",        lat,      LAT);
    check("done_level", o_done,   1'b1);
    check("busy_done",  o_busy,   1'b0);
    check("cap_result", o_result, 8'h5A);
    check("cap_flags",  o_flags,  4'h7);
    @(posedge i_clk); #1;
    check("frame_mosi", mosi_cap[FRAMES*20-1 -: 20], 20'hA53C1);
    check("low_pulses", low_pulses, 20 * FRAMES);
    check("high_pulses", high_pulses, LOAD_CLKS * FRAMES);
    check("frames",     frames,   FRAMES);
    check("done_once",  done_cnt, 1);
    check("done_pulse", o_done,   1'b0);
`ifdef SPI_EXE_MASTER_READBACK_EN
    check("rb_zero_frame", mosi_cap[19:0], 20'h00000);
`endif

    // Second i_start during SHIFT is ignored
    clear_mon();
    @(posedge i_clk); #1;
    i_argA = 8'hA5; i_argB = 8'h3C; i_oper = 4'h1; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    i_argA = 8'hFF; i_argB = 8'hFF; i_oper = 4'hF; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("busy_shift", o_busy, 1'b1);
    wait_done(n);
    check("busy_done_seen", o_done, 1'b1);

    // i_start in the DONE cycle is dropped, the next cycle is accepted
    i_argA = 8'h11; i_argB = 8'h22; i_oper = 4'h3; i_start = 1'b1;
    @(posedge i_clk); #1;
    check("busy_frames", frames, FRAMES);
    check("busy_mosi",   mosi_cap[FRAMES*20-1 -: 20], 20'hA53C1);
    check("start_in_done_ignored", o_busy, 1'b0);
    clear_mon();
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("start_after_done", o_busy, 1'b1);
    wait_done(n);
    check("after_done_seen", o_done, 1'b1);
    check("after_done_mosi", mosi_cap[FRAMES*20-1 -: 20], 20'h11223);

    // Slave loop: answer belongs to the previously loaded command
    auto_resp = 1'b1;
    resp = 20'h5A7C3;
    run_txn(8'h12, 8'h34, 4'h5, lat);
`ifdef SPI_EXE_MASTER_READBACK_EN
    check("loop_c1_result", o_result, 8'h46);
    check("loop_c1_flags",  o_flags,  4'h5);
`else
    check("loop_c1_result", o_result, 8'h5A);
    check("loop_c1_flags",  o_flags,  4'h7);
`endif
    run_txn(8'h40, 8'h07, 4'h9, lat);
    check("loop_lat", lat, LAT);
`ifdef SPI_EXE_MASTER_READBACK_EN
    check("loop_c2_result", o_result, 8'h47);
    check("loop_c2_flags",  o_flags,  4'h9);
`else
    check("loop_c2_result", o_result, 8'h46);
    check("loop_c2_flags",  o_flags,  4'h5);
`endif

    // Reset in the middle of SHIFT
    @(posedge i_clk); #1;
    clear_mon();
    i_argA = 8'h77; i_argB = 8'h88; i_oper = 4'h2; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (30) @(posedge i_clk);
    #1;
    check("pre_rst_cs", o_cs, 1'b0);
    i_rst = 1'b1;
    #1;
    check("mid_rst_cs",     o_cs,     1'b1);
    check("mid_rst_sclk",   o_sclk,   1'b0);
    check("mid_rst_busy",   o_busy,   1'b0);
    check("mid_rst_mosi",   o_mosi,   1'b0);
    check("mid_rst_result", o_result, 8'h00);
    #3;
    i_rst = 1'b0;
    repeat (200) @(posedge i_clk);
    #1;
    check("post_rst_no_done", done_cnt, 0);
    check("post_rst_idle",    o_busy,   1'b0);
    check("post_rst_cs",      o_cs,     1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
